riscv_sequencer: RTL and testbench



---
 rtl/riscv_pkg.sv | 20 ++
 rtl/riscv_sequencer.sv | 139 +++++++++++++
 tb/tb_riscv_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared states, trap causes, bus size codes and NOP for the multi-cycle core
package riscv_pkg;
    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_TRAP  = 3'd4;
    localparam logic [2:0] S_WFI   = 3'd5;
    localparam logic [31:0] CAUSE_IAMA  = 32'd0;
    localparam logic [31:0] CAUSE_ILL   = 32'd2;
    localparam logic [31:0] CAUSE_BRK   = 32'd3;
    localparam logic [31:0] CAUSE_LAMA  = 32'd4;
    localparam logic [31:0] CAUSE_SAMA  = 32'd6;
    localparam logic [31:0] CAUSE_ECALL = 32'd11;
    localparam logic [31:0] CAUSE_IRQ   = 32'h8000_000B;
    localparam logic [1:0] SIZE_B = 2'b01;
    localparam logic [1:0] SIZE_H = 2'b10;
    localparam logic [1:0] SIZE_W = 2'b11;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/riscv_sequencer.sv
// riscv_sequencer: multi-cycle control FSM owning pc, instr and the shared bus port
module riscv_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] instr,
    input  logic        illegal_instruction,
    input  logic        ucoded_instruction,
    input  logic        breakpoint,
    input  logic        ecall,
    input  logic        mret,
    input  logic        wfi,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        is_mem_op,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    output logic [31:0] mem_load_data,
    output logic        irf_we,
    output logic        csr_we,
    input  logic [31:0] mepc_in,
    input  logic [31:0] mtvec,
    input  logic        irq,
    input  logic        irq_en,
    output logic        trap_we,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mcause,
    output logic        retire,
    output logic        bus_req,
    output logic        bus_we,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    logic [2:0]  state;
    logic [31:0] cause;
    logic        run;
    logic        irq_take, ill, misal, ex_trap, exec_ok, in_exec, in_mem;
    logic [31:0] ex_cause;
    logic        unused;
    assign unused = &{1'b0, mtvec[1:0]};
    // run is low for the cycle after reset so no request or strobe leaks out of it
    assign in_exec  = run && state == S_EXEC;
    assign in_mem   = run && state == S_MEM;
    assign irq_take = irq && irq_en;
    assign ill      = illegal_instruction || ucoded_instruction || (is_mem_op && mem_op[1:0] == 2'b00);
    assign misal    = (mem_op[1:0] == SIZE_H && mem_addr[0]) || (mem_op[1:0] == SIZE_W && mem_addr[1:0] != 2'b00);
    always_comb begin
        ex_trap  = irq_take || ill || breakpoint || ecall ||
                   (!mret && !wfi && (is_mem_op ? misal : (jump && jump_target[1])));
        ex_cause = irq_take ? CAUSE_IRQ : ill ? CAUSE_ILL : breakpoint ? CAUSE_BRK :
                   ecall ? CAUSE_ECALL : is_mem_op ? (mem_op[2] ? CAUSE_SAMA : CAUSE_LAMA) : CAUSE_IAMA;
        exec_ok  = in_exec && !ex_trap && !mret && !wfi && !is_mem_op;
    end
    assign bus_req     = (run && state == S_FETCH && pc[1:0] == 2'b00) || in_mem;
    assign bus_we      = in_mem && mem_op[2];
    assign bus_size    = in_mem ? mem_op[1:0] : SIZE_W;
    assign bus_addr    = in_mem ? mem_addr : pc;
    assign bus_wdata   = mem_store_data;
    assign irf_we      = exec_ok || (run && state == S_WB);
    assign csr_we      = exec_ok && instr[6:2] == 5'b11100 && instr[14:12] != 3'b000;
    assign trap_we     = run && state == S_TRAP;
    assign trap_mepc   = pc;
    assign trap_mcause = cause;
    assign retire      = exec_ok || (in_exec && !ex_trap && mret) || (in_mem && bus_ack && mem_op[2]) ||
                         (run && state == S_WB) || (run && state == S_WFI && irq);
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            instr         <= NOP;
            mem_load_data <= 32'h0;
            cause         <= 32'h0;
            run           <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                case (state)
                    S_FETCH: begin
                        if (pc[1:0] != 2'b00) begin
                            cause <= CAUSE_IAMA;
                            state <= S_TRAP;
                        end else if (bus_ack) begin
                            instr <= bus_rdata;
                            state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (ex_trap) begin
                            cause <= ex_cause;
                            state <= S_TRAP;
                        end else if (mret) begin
                            pc    <= mepc_in;
                            state <= S_FETCH;
                        end else if (wfi) begin
                            state <= S_WFI;
                        end else if (is_mem_op) begin
                            state <= S_MEM;
                        end else begin
                            pc    <= jump ? jump_target : pc + 32'd4;
                            state <= S_FETCH;
                        end
                    end
                    S_MEM: begin
                        if (bus_ack && mem_op[2]) begin
                            pc    <= pc + 32'd4;
                            state <= S_FETCH;
                        end else if (bus_ack) begin
                            mem_load_data <= bus_rdata;
                            state         <= S_WB;
                        end
                    end
                    S_WB: begin
                        pc    <= pc + 32'd4;
                        state <= S_FETCH;
                    end
                    S_TRAP: begin
                        pc    <= {mtvec[31:2], 2'b00};
                        state <= S_FETCH;
                    end
                    S_WFI: begin
                        if (irq) begin
                            pc    <= pc + 32'd4;
                            state <= S_FETCH;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_riscv_sequencer.sv
// tb_riscv_sequencer: directed scenario tests for riscv_sequencer with a hand-driven bus and datapath
module tb_riscv_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc, instr, mem_load_data, trap_mepc, trap_mcause, bus_addr, bus_wdata;
    logic        irf_we, csr_we, trap_we, retire, bus_req, bus_we;
    logic [1:0]  bus_size;
    logic        illegal_instruction = 0, ucoded_instruction = 0, breakpoint = 0, ecall = 0;
    logic        mret = 0, wfi = 0, jump = 0, is_mem_op = 0, irq = 0, irq_en = 0, bus_ack = 0;
    logic [31:0] jump_target = 0, mem_addr = 0, mem_store_data = 0, bus_rdata = 0;
    logic [31:0] mepc_in = 32'h0, mtvec = 32'h0000_0303;
    logic [2:0]  mem_op = 0;
    int total = 0, bad = 0;

    riscv_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr),
        .illegal_instruction(illegal_instruction), .ucoded_instruction(ucoded_instruction),
        .breakpoint(breakpoint), .ecall(ecall), .mret(mret), .wfi(wfi), .jump(jump),
        .jump_target(jump_target), .is_mem_op(is_mem_op), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_store_data(mem_store_data), .mem_load_data(mem_load_data), .irf_we(irf_we),
        .csr_we(csr_we), .mepc_in(mepc_in), .mtvec(mtvec), .irq(irq), .irq_en(irq_en),
        .trap_we(trap_we), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause), .retire(retire),
        .bus_req(bus_req), .bus_we(bus_we), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] word);
        bus_rdata = word;
        bus_ack   = 1'b1;
        step();
        bus_ack   = 1'b0;
    endtask

    task automatic clear_flags();
        {illegal_instruction, ucoded_instruction, breakpoint, ecall, mret, wfi, jump, is_mem_op, irq, irq_en} = '0;
        mem_op = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total += 5;
        if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
        if (pc !== 32'h100) begin bad++; $display("FAIL reset_pc got=%h exp=00000100", pc); end
        if (instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", instr); end
        if (mem_load_data !== 32'h0) begin bad++; $display("FAIL reset_mld got=%h exp=0", mem_load_data); end
        if ({irf_we, csr_we, trap_we, retire} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {irf_we, csr_we, trap_we, retire}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu();
        total += 6;
        if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0 || bus_size !== 2'b11) begin
            bad++; $display("FAIL alu_fetch got req=%b addr=%h we=%b size=%b exp req=1 addr=00000100 we=0 size=11", bus_req, bus_addr, bus_we, bus_size);
        end
        fetch(32'h0050_0093);
        if (instr !== 32'h0050_0093) begin bad++; $display("FAIL alu_instr got=%h exp=00500093", instr); end
        if (irf_we !== 1'b1 || retire !== 1'b1) begin bad++; $display("FAIL alu_exec got irf_we=%b retire=%b exp 1 1", irf_we, retire); end
        if (csr_we !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL alu_quiet got csr_we=%b bus_req=%b exp 0 0", csr_we, bus_req); end
        step();
        if (pc !== 32'h104) begin bad++; $display("FAIL alu_pc got=%h exp=00000104", pc); end
        if (bus_addr !== 32'h104) begin bad++; $display("FAIL alu_next_fetch got=%h exp=00000104", bus_addr); end
    endtask

    task automatic test_load();
        is_mem_op = 1'b1; mem_op = 3'b011; mem_addr = 32'h200;
        fetch(32'h2000_2083);
        total += 1;
        if (irf_we !== 1'b0 || retire !== 1'b0) begin bad++; $display("FAIL load_exec got irf_we=%b retire=%b exp 0 0", irf_we, retire); end
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus_req !== 1'b1 || bus_addr !== 32'h200 || bus_we !== 1'b0 || bus_size !== 2'b11) begin
                bad++; $display("FAIL load_hold%0d got req=%b addr=%h we=%b size=%b exp 1 00000200 0 11", i, bus_req, bus_addr, bus_we, bus_size);
            end
            if (i < 3) step();
        end
        bus_rdata = 32'hDEAD_BEEF; bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        total += 3;
        if (mem_load_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_data got=%h exp=deadbeef", mem_load_data); end
        if (irf_we !== 1'b1 || retire !== 1'b1) begin bad++; $display("FAIL load_wb got irf_we=%b retire=%b exp 1 1", irf_we, retire); end
        if (bus_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%b exp=0", bus_req); end
        step();
        total++;
        if (pc !== 32'h108) begin bad++; $display("FAIL load_pc got=%h exp=00000108", pc); end
        clear_flags();
    endtask

    task automatic test_misaligned_store();
        is_mem_op = 1'b1; mem_op = 3'b110; mem_addr = 32'h201;
        fetch(32'h0011_10A3);
        total++;
        if (retire !== 1'b0 || irf_we !== 1'b0) begin bad++; $display("FAIL sh_exec got retire=%b irf_we=%b exp 0 0", retire, irf_we); end
        step();
        total += 2;
        if (trap_we !== 1'b1 || trap_mcause !== 32'd6 || trap_mepc !== 32'h108) begin
            bad++; $display("FAIL sh_trap got we=%b cause=%h mepc=%h exp 1 00000006 00000108", trap_we, trap_mcause, trap_mepc);
        end
        if (bus_req !== 1'b0) begin bad++; $display("FAIL sh_no_req got=%b exp=0", bus_req); end
        clear_flags();
        step();
        total++;
        if (pc !== 32'h300 || trap_we !== 1'b0) begin bad++; $display("FAIL sh_vector got pc=%h trap_we=%b exp 00000300 0", pc, trap_we); end
    endtask

    task automatic test_irq();
        jump = 1'b1; jump_target = 32'h400; irq = 1'b1; irq_en = 1'b1;
        fetch(32'h0000_0063);
        total++;
        if (retire !== 1'b0 || irf_we !== 1'b0) begin bad++; $display("FAIL irq_exec got retire=%b irf_we=%b exp 0 0", retire, irf_we); end
        step();
        clear_flags();
        total++;
        if (trap_we !== 1'b1 || trap_mcause !== 32'h8000_000B || trap_mepc !== 32'h300) begin
            bad++; $display("FAIL irq_trap got we=%b cause=%h mepc=%h exp 1 8000000b 00000300", trap_we, trap_mcause, trap_mepc);
        end
        step();
        total++;
        if (pc !== 32'h300) begin bad++; $display("FAIL irq_pc got=%h exp=00000300", pc); end
    endtask

    task automatic test_wfi();
        wfi = 1'b1;
        fetch(32'h1050_0073);
        total++;
        if (retire !== 1'b0) begin bad++; $display("FAIL wfi_exec got retire=%b exp 0", retire); end
        step();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (retire !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL wfi_idle%0d got retire=%b req=%b exp 0 0", i, retire, bus_req); end
            step();
        end
        irq = 1'b1;
        #1;
        total++;
        if (retire !== 1'b1) begin bad++; $display("FAIL wfi_wake got retire=%b exp 1", retire); end
        step();
        clear_flags();
        total++;
        if (pc !== 32'h304 || bus_addr !== 32'h304 || bus_req !== 1'b1) begin
            bad++; $display("FAIL wfi_pc got pc=%h addr=%h req=%b exp 00000304 00000304 1", pc, bus_addr, bus_req);
        end
    endtask

    task automatic test_store();
        is_mem_op = 1'b1; mem_op = 3'b111; mem_addr = 32'h210; mem_store_data = 32'h1234_5678;
        fetch(32'h0011_2823);
        step();
        total++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_size !== 2'b11 || bus_addr !== 32'h210 || bus_wdata !== 32'h1234_5678) begin
            bad++; $display("FAIL sw_bus got req=%b we=%b size=%b addr=%h wdata=%h exp 1 1 11 00000210 12345678", bus_req, bus_we, bus_size, bus_addr, bus_wdata);
        end
        bus_ack = 1'b1;
        #1;
        total++;
        if (retire !== 1'b1 || irf_we !== 1'b0) begin bad++; $display("FAIL sw_retire got retire=%b irf_we=%b exp 1 0", retire, irf_we); end
        step();
        bus_ack = 1'b0;
        clear_flags();
        total++;
        if (pc !== 32'h308) begin bad++; $display("FAIL sw_pc got=%h exp=00000308", pc); end
    endtask

    task automatic test_csr_jump();
        fetch(32'h3052_9073);
        total++;
        if (csr_we !== 1'b1 || irf_we !== 1'b1) begin bad++; $display("FAIL csr_we got csr_we=%b irf_we=%b exp 1 1", csr_we, irf_we); end
        step();
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        fetch(32'h0000_006F);
        total++;
        if (retire !== 1'b1 || csr_we !== 1'b0) begin bad++; $display("FAIL jal_exec got retire=%b csr_we=%b exp 1 0", retire, csr_we); end
        step();
        clear_flags();
        total++;
        if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL jal_pc got=%h exp=fffffffc", pc); end
        fetch(32'h0050_0093);
        step();
        total++;
        if (pc !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=00000000", pc); end
        jump = 1'b1; jump_target = 32'h402;
        fetch(32'h0000_006F);
        total++;
        if (retire !== 1'b0) begin bad++; $display("FAIL jmis_exec got retire=%b exp 0", retire); end
        step();
        clear_flags();
        total++;
        if (trap_we !== 1'b1 || trap_mcause !== 32'd0 || trap_mepc !== 32'h0) begin
            bad++; $display("FAIL jmis_trap got we=%b cause=%h mepc=%h exp 1 00000000 00000000", trap_we, trap_mcause, trap_mepc);
        end
        step();
    endtask

    task automatic test_ecall();
        ecall = 1'b1;
        fetch(32'h0000_0073);
        step();
        clear_flags();
        total++;
        if (trap_we !== 1'b1 || trap_mcause !== 32'd11 || trap_mepc !== 32'h300) begin
            bad++; $display("FAIL ecall_trap got we=%b cause=%h mepc=%h exp 1 0000000b 00000300", trap_we, trap_mcause, trap_mepc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        is_mem_op = 1'b1; mem_op = 3'b011; mem_addr = 32'h200;
        fetch(32'h2000_2083);
        step();
        total++;
        if (bus_req !== 1'b1) begin bad++; $display("FAIL rmid_req_before got=%b exp=1", bus_req); end
        rst = 1'b1;
        step();
        total++;
        if (bus_req !== 1'b0 || pc !== 32'h100 || irf_we !== 1'b0) begin
            bad++; $display("FAIL rmid_after got req=%b pc=%h irf_we=%b exp 0 00000100 0", bus_req, pc, irf_we);
        end
        rst = 1'b0;
        clear_flags();
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_misaligned_store();
        test_irq();
        test_wfi();
        test_store();
        test_csr_jump();
        test_ecall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
